// File: rtl/mp1000_pkg.sv
// Shared types and default sizing for the MP1000 BRAM arbiter and download buffer.
package mp1000_pkg;
  localparam int         MP1000_ADDR_W      = 14;
  localparam logic [7:0] MP1000_CART_INDEX  = 8'd1;
  localparam int         MP1000_CPU_REL_DLY = 16;

  typedef enum logic [1:0] {IDLE, DL_WR, RD_WAIT} arb_state_t;
  typedef enum logic       {OWN_VID, OWN_CPU}     owner_t;
endpackage

// File: rtl/mp1000_dl_buffer.sv
// One-entry capture register for HPS cartridge download bytes, with sticky overflow.
// MP1000_DL_CHECKSUM_EN adds a running 16-bit byte sum (dl_sum) per matching download.
module mp1000_dl_buffer
  import mp1000_pkg::*;
#(
  parameter int         ADDR_W     = MP1000_ADDR_W,
  parameter logic [7:0] CART_INDEX = MP1000_CART_INDEX
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              take,
  output logic              full,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_data,
  output logic              dl_match,
  output logic              dl_overflow
`ifdef MP1000_DL_CHECKSUM_EN
  ,
  output logic [15:0]       dl_sum
`endif
);

  logic strobe;
  logic accept;
  logic unused_addr_hi;

  assign dl_match       = ioctl_download && (ioctl_index == CART_INDEX);
  assign strobe         = ioctl_wr && dl_match;
  // The arbiter consumes the entry on the same edge, so a strobe then still fits.
  assign accept         = strobe && (!full || take);
  assign unused_addr_hi = ^ioctl_addr[24:ADDR_W];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      full        <= 1'b0;
      buf_addr    <= '0;
      buf_data    <= '0;
      dl_overflow <= 1'b0;
    end else begin
      if (accept) begin
        full     <= 1'b1;
        buf_addr <= ioctl_addr[ADDR_W-1:0];
        buf_data <= ioctl_dout;
      end else if (take) begin
        full <= 1'b0;
      end
      if (strobe && !accept) dl_overflow <= 1'b1;
    end
  end

`ifdef MP1000_DL_CHECKSUM_EN
  logic dl_match_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_match_q <= 1'b0;
      dl_sum     <= '0;
    end else begin
      dl_match_q <= dl_match;
      if (dl_match && !dl_match_q)
        dl_sum <= accept ? {8'h00, ioctl_dout} : 16'h0000;
      else if (accept)
        dl_sum <= dl_sum + {8'h00, ioctl_dout};
    end
  end
`endif

endmodule

// File: rtl/mp1000_mem_arbiter.sv
// Fixed-priority BRAM arbiter (download > video > CPU) with CPU halt during cart load.
// MP1000_DL_CHECKSUM_EN exposes dl_sum from the download buffer.
module mp1000_mem_arbiter
  import mp1000_pkg::*;
#(
  parameter int         ADDR_W      = MP1000_ADDR_W,
  parameter logic [7:0] CART_INDEX  = MP1000_CART_INDEX,
  parameter int         CPU_REL_DLY = MP1000_CPU_REL_DLY
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              vid_req,
  output logic              vid_ack,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic              cpu_req,
  output logic              cpu_ack,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        rd_data,
  output logic              cpu_halt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  input  logic [7:0]        mem_dout,
  output logic              dl_overflow
`ifdef MP1000_DL_CHECKSUM_EN
  ,
  output logic [15:0]       dl_sum
`endif
);

  localparam int               CNT_W    = $clog2(CPU_REL_DLY + 1);
  localparam logic [CNT_W-1:0] REL_LOAD = CNT_W'(CPU_REL_DLY);

  arb_state_t        state;
  owner_t            owner;
  logic [CNT_W-1:0]  rel_cnt;
  logic              buf_full;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_data;
  logic              dl_match;
  logic              buf_take;

  assign buf_take = (state == IDLE) && buf_full;

  mp1000_dl_buffer #(
    .ADDR_W     (ADDR_W),
    .CART_INDEX (CART_INDEX)
  ) u_dl_buffer (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .take           (buf_take),
    .full           (buf_full),
    .buf_addr       (buf_addr),
    .buf_data       (buf_data),
    .dl_match       (dl_match),
    .dl_overflow    (dl_overflow)
`ifdef MP1000_DL_CHECKSUM_EN
    ,
    .dl_sum         (dl_sum)
`endif
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= OWN_VID;
      vid_ack  <= 1'b0;
      cpu_ack  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      rd_data  <= '0;
    end else begin
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (buf_full) begin
            mem_addr <= buf_addr;
            mem_din  <= buf_data;
            mem_we   <= 1'b1;
            state    <= DL_WR;
          end else if (vid_req) begin
            mem_addr <= vid_addr;
            owner    <= OWN_VID;
            state    <= RD_WAIT;
          end else if (cpu_req && !cpu_halt) begin
            mem_addr <= cpu_addr;
            if (cpu_we) begin
              mem_din <= cpu_din;
              mem_we  <= 1'b1;
              cpu_ack <= 1'b1;
            end else begin
              owner <= OWN_CPU;
              state <= RD_WAIT;
            end
          end
        end
        DL_WR: state <= IDLE;
        RD_WAIT: begin
          rd_data <= mem_dout;
          if (owner == OWN_VID) vid_ack <= 1'b1;
          else                  cpu_ack <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Halt follows a matching download, then holds CPU_REL_DLY cycles after it falls.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rel_cnt  <= REL_LOAD;
      cpu_halt <= 1'b1;
    end else if (dl_match) begin
      rel_cnt  <= REL_LOAD;
      cpu_halt <= 1'b1;
    end else if (rel_cnt != '0) begin
      rel_cnt  <= rel_cnt - 1'b1;
      cpu_halt <= (rel_cnt != CNT_W'(1));
    end else begin
      cpu_halt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mp1000_mem_arbiter.sv
// Self-checking bench for mp1000_mem_arbiter: vector table, corner sequences, random ops.
// Build with MP1000_DL_CHECKSUM_EN to also check dl_sum.
module tb_mp1000_mem_arbiter;
  localparam int AW = 14;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic [7:0]    ioctl_index = 8'd0;
  logic          ioctl_wr = 1'b0;
  logic [24:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic          vid_req = 1'b0;
  logic          vid_ack;
  logic [AW-1:0] vid_addr = '0;
  logic          cpu_req = 1'b0;
  logic          cpu_ack;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_din = '0;
  logic [7:0]    rd_data;
  logic          cpu_halt;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_we;
  logic [7:0]    mem_dout;
  logic          dl_overflow;
`ifdef MP1000_DL_CHECKSUM_EN
  logic [15:0]   dl_sum;
`endif

  mp1000_mem_arbiter dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .vid_req        (vid_req),
    .vid_ack        (vid_ack),
    .vid_addr       (vid_addr),
    .cpu_req        (cpu_req),
    .cpu_ack        (cpu_ack),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_din        (cpu_din),
    .rd_data        (rd_data),
    .cpu_halt       (cpu_halt),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_we         (mem_we),
    .mem_dout       (mem_dout),
    .dl_overflow    (dl_overflow)
`ifdef MP1000_DL_CHECKSUM_EN
    ,
    .dl_sum         (dl_sum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  // BRAM: data for the address registered at an edge is valid during the following cycle.
  logic [7:0] bram [0:(1<<AW)-1];
  always @(posedge clk_sys) if (mem_we) bram[mem_addr] <= mem_din;
  assign mem_dout = bram[mem_addr];

  // Reference model: plain byte array plus the list of addresses that hold known data.
  logic [7:0]    model_mem [0:(1<<AW)-1];
  logic [AW-1:0] known_q[$];

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            vid;
    bit            we;
    logic [AW-1:0] addr;
    logic [7:0]    din;
    logic [7:0]    exp_rd;
    int            exp_lat;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [7:0] d);
    model_mem[a] = d;
    known_q.push_back(a);
  endtask

  task automatic do_op(input bit vid, input bit we, input logic [AW-1:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] rd);
    @(negedge clk_sys);
    if (vid) begin
      vid_req = 1'b1; vid_addr = a;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
    end
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (vid ? vid_ack : cpu_ack) break;
    end
    rd = rd_data;
    vid_req = 1'b0;
    cpu_req = 1'b0;
  endtask

  task automatic dual_read(input logic [AW-1:0] va, input logic [AW-1:0] ca,
                           output int vlat, output int clat, output logic [7:0] vd, output logic [7:0] cd);
    @(negedge clk_sys);
    vid_req = 1'b1; vid_addr = va;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ca;
    vlat = 0; clat = 0; vd = '0; cd = '0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (vid_req && vid_ack) begin vlat = k; vd = rd_data; vid_req = 1'b0; end
      if (cpu_req && cpu_ack) begin clat = k; cd = rd_data; cpu_req = 1'b0; end
      if (!vid_req && !cpu_req) break;
    end
    vid_req = 1'b0;
    cpu_req = 1'b0;
  endtask

  task automatic wait_halt_low(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (cpu_halt && n < 100);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n, lat, vlat, clat, dl_bad, stray;
    logic [7:0]    rd, vd, cd, d;
    logic [AW-1:0] a, ca;
    logic [24:0]   ia;
    logic [15:0]   exp_sum;

    vecs[0] = '{1'b0, 1'b1, 14'h0010, 8'hA5, 8'h00, 1};
    vecs[1] = '{1'b0, 1'b0, 14'h0010, 8'h00, 8'hA5, 2};
    vecs[2] = '{1'b0, 1'b1, 14'h1234, 8'h5A, 8'h00, 1};
    vecs[3] = '{1'b1, 1'b0, 14'h1234, 8'h00, 8'h5A, 2};
    vecs[4] = '{1'b0, 1'b1, 14'h3FFF, 8'hC3, 8'h00, 1};
    vecs[5] = '{1'b0, 1'b0, 14'h3FFF, 8'h00, 8'hC3, 2};
    vecs[6] = '{1'b0, 1'b1, 14'h0000, 8'h01, 8'h00, 1};
    vecs[7] = '{1'b1, 1'b0, 14'h0000, 8'h00, 8'h01, 2};
    vecs[8] = '{1'b0, 1'b1, 14'h0010, 8'h5C, 8'h00, 1};
    vecs[9] = '{1'b1, 1'b0, 14'h0010, 8'h00, 8'h5C, 2};

    // Reset values and the post-reset halt window
    repeat (3) tick();
    check("rst_outputs", {vid_ack, cpu_ack, mem_we, dl_overflow}, 4'b0000);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_cpu_halt", cpu_halt, 1);
    @(negedge clk_sys);
    reset = 1'b0;
    n = 0; stray = 0;
    do begin
      tick();
      n++;
      if (vid_ack || cpu_ack || mem_we) stray++;
    end while (cpu_halt && n < 100);
    check("halt_after_reset_cycles", n, 16);
    repeat (4) begin
      tick();
      if (vid_ack || cpu_ack || mem_we) stray++;
    end
    check("idle_no_activity", stray, 0);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].vid, vecs[i].we, vecs[i].addr, vecs[i].din, lat, rd);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      if (!vecs[i].we) check($sformatf("vec%0d_rd_data", i), rd, vecs[i].exp_rd);
      else model_write(vecs[i].addr, vecs[i].din);
    end

    // Video and CPU read in the same cycle: video first, CPU two cycles later
    dual_read(14'h0000, 14'h1234, vlat, clat, vd, cd);
    check("dual_vid_latency", vlat, 2);
    check("dual_vid_data", vd, 8'h01);
    check("dual_cpu_latency", clat, 4);
    check("dual_cpu_data", cd, 8'h5A);

    // 256-byte cartridge download, half of it with high ioctl_addr bits set
    @(negedge clk_sys);
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    tick(); tick();
    @(negedge clk_sys);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h3000;
    dl_bad = 0; exp_sum = '0;
    for (int i = 0; i < 256; i++) begin
      d  = 8'(i * 7 + 3);
      ia = (i < 128) ? 25'(i) : {11'h7FF, 14'(i)};
      @(negedge clk_sys);
      ioctl_wr = 1'b1; ioctl_addr = ia; ioctl_dout = d;
      for (int c = 0; c < 4; c++) begin
        tick();
        ioctl_wr = 1'b0;
        if (!cpu_halt || cpu_ack) dl_bad++;
      end
      model_write(ia[AW-1:0], d);
      exp_sum = exp_sum + 16'(d);
    end
    @(negedge clk_sys);
    cpu_req = 1'b0;
    tick();
    check("dl_halt_and_no_cpu_ack", dl_bad, 0);
    check("dl_no_overflow", dl_overflow, 0);
`ifdef MP1000_DL_CHECKSUM_EN
    check("dl_sum_256", dl_sum, exp_sum);
`endif
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    wait_halt_low(n);
    check("halt_after_download_cycles", n, 16);
    for (int i = 0; i < 256; i++) begin
      a = 14'(i);
      do_op(1'b0, 1'b0, a, 8'h00, lat, rd);
      check($sformatf("dl_readback_%0h", i), rd, model_mem[a]);
    end

    // Download on another slot is ignored
    @(negedge clk_sys);
    ioctl_index = 8'd2; ioctl_download = 1'b1;
    tick();
    @(negedge clk_sys);
    ioctl_wr = 1'b1; ioctl_addr = 25'h0050; ioctl_dout = ~model_mem[14'h0050];
    tick();
    ioctl_wr = 1'b0;
    tick(); tick();
    check("other_index_no_halt", cpu_halt, 0);
    @(negedge clk_sys);
    ioctl_download = 1'b0; ioctl_index = 8'd1;
    do_op(1'b0, 1'b0, 14'h0050, 8'h00, lat, rd);
    check("other_index_no_write", rd, model_mem[14'h0050]);

    // Three consecutive strobes: the second fits as the first drains, the third is lost
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    tick(); tick();
    @(negedge clk_sys);
    ioctl_wr = 1'b1; ioctl_addr = 25'h00F0; ioctl_dout = 8'h11;
    tick();
    check("ovf_after_strobe1", dl_overflow, 0);
    ioctl_addr = 25'h00F1; ioctl_dout = 8'h22;
    tick();
    check("ovf_after_strobe2", dl_overflow, 0);
    ioctl_addr = 25'h00F2; ioctl_dout = 8'h33;
    tick();
    check("ovf_after_strobe3", dl_overflow, 1);
    ioctl_wr = 1'b0;
    model_write(14'h00F0, 8'h11);
    model_write(14'h00F1, 8'h22);
    repeat (4) tick();
`ifdef MP1000_DL_CHECKSUM_EN
    check("dl_sum_burst", dl_sum, 16'h0033);
`endif
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    wait_halt_low(n);
    for (int i = 0; i < 3; i++) begin
      a = 14'h00F0 + 14'(i);
      do_op(1'b0, 1'b0, a, 8'h00, lat, rd);
      check($sformatf("burst_readback_%0d", i), rd, model_mem[a]);
    end
    check("ovf_sticky", dl_overflow, 1);

    // Reset while a video read is in RD_WAIT
    @(negedge clk_sys);
    vid_req = 1'b1; vid_addr = 14'h0010;
    tick();
    reset = 1'b1;
    tick();
    check("rst_rdwait_no_ack", {vid_ack, cpu_ack, mem_we}, 3'b000);
    vid_req = 1'b0;
    tick();
    check("rst_clears_overflow", dl_overflow, 0);
    check("rst_sets_halt", cpu_halt, 1);
    @(negedge clk_sys);
    reset = 1'b0;
    wait_halt_low(n);
    check("halt_after_rst2_cycles", n, 16);

    // Random traffic against the model
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = 14'($urandom); d = 8'($urandom);
          do_op(1'b0, 1'b1, a, d, lat, rd);
          check("rnd_wr_latency", lat, 1);
          model_write(a, d);
        end
        1, 2: begin
          a = known_q[$urandom_range(0, known_q.size() - 1)];
          do_op(it[0], 1'b0, a, 8'h00, lat, rd);
          check("rnd_rd_latency", lat, 2);
          check($sformatf("rnd_rd_data_%0h", a), rd, model_mem[a]);
        end
        default: begin
          a  = known_q[$urandom_range(0, known_q.size() - 1)];
          ca = known_q[$urandom_range(0, known_q.size() - 1)];
          dual_read(a, ca, vlat, clat, vd, cd);
          check("rnd_dual_vid_latency", vlat, 2);
          check("rnd_dual_cpu_latency", clat, 4);
          check("rnd_dual_vid_data", vd, model_mem[a]);
          check("rnd_dual_cpu_data", cd, model_mem[ca]);
        end
      endcase
    end

`ifdef MP1000_DL_CHECKSUM_EN
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    tick();
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_sys);
      ioctl_wr = 1'b1; ioctl_addr = 25'h0300 + 25'(i); ioctl_dout = 8'(i);
      for (int c = 0; c < 4; c++) begin
        tick();
        ioctl_wr = 1'b0;
      end
      model_write(14'h0300 + 14'(i), 8'(i));
    end
    check("dl_sum_1_to_10", dl_sum, 16'd55);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    repeat (3) tick();
    check("dl_sum_held", dl_sum, 16'd55);
    wait_halt_low(n);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
